// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory round-robin arbiter: FSM state encodings and a width helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Number of bits needed to hold the values 0..value-1.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) bits = i + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping mod NUM_REQ.
// Zero latency; no flow control of its own.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any_valid,
   output logic [ID_W-1:0]    grant_id
);

   always_comb begin
      logic [ID_W:0] slot;
      any_valid = 1'b0;
      grant_id  = '0;
      slot      = '0;
      // Scan from the farthest slot to the nearest so the nearest set bit is the last writer.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         slot = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (slot >= (ID_W + 1)'(NUM_REQ))
            slot = slot - (ID_W + 1)'(NUM_REQ);
         if (req[slot[ID_W-1:0]]) begin
            any_valid = 1'b1;
            grant_id  = slot[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin share of one single-port memory controller; grant->strobe 1 cycle, rsp 1 cycle after mc_ready.
// One transaction in flight: requesters wait on req_ready; a watchdog returns an error rsp if mc_ready never comes.
module mem_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          busy,
   output logic                          mc_wr_en,
   output logic                          mc_rd_en,
   output logic [ADDR_WIDTH-1:0]         mc_addr,
   output logic [DATA_WIDTH-1:0]         mc_wr_data,
   input  logic [DATA_WIDTH-1:0]         mc_rd_data,
   input  logic                          mc_ready
);

   import mem_arb_pkg::*;

   localparam int ID_W = clog2(NUM_REQ);
   localparam int WD_W = clog2(TIMEOUT + 1);

   state_t                state;
   state_t                state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       cur_id;
   logic                  cur_we;
   logic [WD_W-1:0]       watchdog;
   logic                  any_valid;
   logic [ID_W-1:0]       grant_id;
   logic                  do_grant;
   logic                  rsp_ok;
   logic                  rsp_timeout;
   logic                  wd_expired;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      return NUM_REQ'(1) << id;
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .any_valid (any_valid),
      .grant_id  (grant_id)
   );

   // Last WAIT cycle before the error response; mc_ready arriving here still wins.
   assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      do_grant    = 1'b0;
      rsp_ok      = 1'b0;
      rsp_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_valid) begin
               do_grant  = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (mc_ready) begin
               rsp_ok    = 1'b1;
               state_nxt = ST_IDLE;
            end else if (wd_expired) begin
               rsp_timeout = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         cur_id     <= '0;
         cur_we     <= 1'b0;
         watchdog   <= '0;
         req_ready  <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         mc_wr_en   <= 1'b0;
         mc_rd_en   <= 1'b0;
         mc_addr    <= '0;
         mc_wr_data <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         mc_wr_en  <= 1'b0;
         mc_rd_en  <= 1'b0;
         busy      <= (state_nxt != ST_IDLE);

         // Command fields are captured here and held until the next grant.
         if (do_grant) begin
            cur_id     <= grant_id;
            cur_we     <= req_we[grant_id];
            mc_addr    <= addr_arr[grant_id];
            mc_wr_data <= wdata_arr[grant_id];
            mc_wr_en   <= req_we[grant_id];
            mc_rd_en   <= ~req_we[grant_id];
            req_ready  <= onehot(grant_id);
         end

         if (state == ST_ISSUE) begin
            rr_ptr   <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            watchdog <= '0;
         end

         if (state == ST_WAIT)
            watchdog <= watchdog + 1'b1;

         if (rsp_ok) begin
            rsp_valid <= onehot(cur_id);
            rsp_err   <= 1'b0;
            watchdog  <= '0;
            if (!cur_we)
               rsp_rdata <= mc_rd_data;
         end

         if (rsp_timeout) begin
            rsp_valid <= onehot(cur_id);
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            watchdog  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a 2-cycle controller model and injectable mc_ready pulses.
module tb_mem_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        mc_wr_en;
   logic        mc_rd_en;
   logic [7:0]  mc_addr;
   logic [7:0]  mc_wr_data;
   logic [7:0]  mc_rd_data;
   logic        mc_ready;

   int          errors = 0;
   int          checks = 0;

   logic [7:0]  mem [256];
   int          cnt;
   logic [7:0]  pend_addr;
   bit          ctrl_on;
   bit          inj_ready;
   logic [7:0]  inj_data;

   mem_rr_arbiter #(
      .NUM_REQ    (4),
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .TIMEOUT    (15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .mc_wr_en   (mc_wr_en),
      .mc_rd_en   (mc_rd_en),
      .mc_addr    (mc_addr),
      .mc_wr_data (mc_wr_data),
      .mc_rd_data (mc_rd_data),
      .mc_ready   (mc_ready)
   );

   always #5 clk = ~clk;

   // Advance one cycle, then play the controller: ready two cycles after a strobe.
   task automatic step();
      @(posedge clk);
      #1;
      mc_ready = 1'b0;
      if (cnt != 0) begin
         cnt = cnt - 1;
         if (cnt == 0 && ctrl_on) begin
            mc_ready   = 1'b1;
            mc_rd_data = mem[pend_addr];
         end
      end
      if (mc_wr_en) begin
         mem[mc_addr] = mc_wr_data;
         pend_addr    = mc_addr;
         cnt          = 2;
      end
      if (mc_rd_en) begin
         pend_addr = mc_addr;
         cnt       = 2;
      end
      if (inj_ready) begin
         mc_ready   = 1'b1;
         mc_rd_data = inj_data;
         inj_ready  = 1'b0;
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
      req_valid[i]       = 1'b1;
      req_we[i]          = we;
      req_addr[i*8 +: 8] = a;
      req_wdata[i*8 +: 8] = d;
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1;
      step();
      step();
      checks++; if ({req_ready, rsp_valid, rsp_err, busy, mc_wr_en, mc_rd_en} !== 12'h000) begin
         errors++; $display("FAIL reset_ctrl: got %h required 000", {req_ready, rsp_valid, rsp_err, busy, mc_wr_en, mc_rd_en}); end
      checks++; if ({rsp_rdata, mc_addr, mc_wr_data} !== 24'h000000) begin
         errors++; $display("FAIL reset_data: got %h required 000000", {rsp_rdata, mc_addr, mc_wr_data}); end
      rst = 1'b0;
      step();
      set_req(2, 1'b0, 8'h33, 8'h00);
      step();
      checks++; if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL rst_pre_grant: got %b required 0100", req_ready); end
      req_valid[2] = 1'b0;
      step();
      checks++; if (busy !== 1'b1) begin
         errors++; $display("FAIL rst_pre_busy: got %b required 1", busy); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({busy, req_ready, rsp_valid, mc_wr_en, mc_rd_en, mc_addr} !== 19'h0) begin
         errors++; $display("FAIL rst_async: got %h required 0", {busy, req_ready, rsp_valid, mc_wr_en, mc_rd_en, mc_addr}); end
      step();
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         step();
         if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin
         errors++; $display("FAIL rst_no_rsp: got %0d stray cycles required 0", seen); end
      set_req(2, 1'b0, 8'h00, 8'h00);
      set_req(3, 1'b0, 8'h00, 8'h00);
      step();
      checks++; if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL rst_ptr_restart: got %b required 0100", req_ready); end
      req_valid[2] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL rst_rsp2: got %b err %b required 0100 err 0", rsp_valid, rsp_err); end
      step();
      checks++; if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL rst_grant3: got %b required 1000", req_ready); end
      req_valid[3] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b1000) begin
         errors++; $display("FAIL rst_rsp3: got %b required 1000", rsp_valid); end
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] grant_seq [5];
      logic [7:0] rdata_seq [5];
      logic [3:0] exp_rdy;
      logic [3:0] exp_rsp;
      grant_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rdata_seq = '{8'h83, 8'h82, 8'h81, 8'h80, 8'h83};
      set_req(0, 1'b0, 8'h40, 8'h00);
      set_req(1, 1'b0, 8'h41, 8'h00);
      set_req(2, 1'b0, 8'h42, 8'h00);
      set_req(3, 1'b0, 8'h43, 8'h00);
      for (int c = 1; c <= 20; c++) begin
         step();
         exp_rdy = (c % 4 == 1) ? grant_seq[(c - 1) / 4] : 4'b0000;
         exp_rsp = (c % 4 == 0) ? grant_seq[c / 4 - 1] : 4'b0000;
         checks++; if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL rr_ready c%0d: got %b required %b", c, req_ready, exp_rdy); end
         checks++; if (rsp_valid !== exp_rsp) begin
            errors++; $display("FAIL rr_rsp c%0d: got %b required %b", c, rsp_valid, exp_rsp); end
         if (c % 4 == 0) begin
            checks++; if (rsp_rdata !== rdata_seq[c / 4 - 1]) begin
               errors++; $display("FAIL rr_rdata c%0d: got %h required %h", c, rsp_rdata, rdata_seq[c / 4 - 1]); end
         end
         if (c == 17) req_valid = 4'b0000;
      end
   endtask

   task automatic test_single_write();
      set_req(0, 1'b1, 8'h10, 8'hA5);
      step();
      checks++; if (req_ready !== 4'b0001 || busy !== 1'b1) begin
         errors++; $display("FAIL wr_grant: got %b busy %b required 0001 busy 1", req_ready, busy); end
      checks++; if ({mc_wr_en, mc_rd_en, mc_addr, mc_wr_data} !== {2'b10, 8'h10, 8'hA5}) begin
         errors++; $display("FAIL wr_cmd: got %h required %h", {mc_wr_en, mc_rd_en, mc_addr, mc_wr_data}, {2'b10, 8'h10, 8'hA5}); end
      req_valid[0] = 1'b0;
      req_addr[7:0]  = 8'hEE;
      req_wdata[7:0] = 8'h00;
      step();
      checks++; if ({mc_wr_en, mc_addr, mc_wr_data} !== {1'b0, 8'h10, 8'hA5}) begin
         errors++; $display("FAIL wr_hold: got %h required %h", {mc_wr_en, mc_addr, mc_wr_data}, {1'b0, 8'h10, 8'hA5}); end
      step();
      step();
      checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL wr_rsp: got %b err %b busy %b required 0001 0 0", rsp_valid, rsp_err, busy); end
      checks++; if (rsp_rdata !== 8'h83) begin
         errors++; $display("FAIL wr_rdata_kept: got %h required 83", rsp_rdata); end
   endtask

   task automatic test_readback();
      set_req(2, 1'b0, 8'h10, 8'h00);
      step();
      checks++; if (req_ready !== 4'b0100 || mc_rd_en !== 1'b1 || mc_wr_en !== 1'b0 || mc_addr !== 8'h10) begin
         errors++; $display("FAIL rd_cmd: got %b rd %b wr %b addr %h required 0100 1 0 10", req_ready, mc_rd_en, mc_wr_en, mc_addr); end
      req_valid[2] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL rd_rsp: got %b %h err %b required 0100 a5 0", rsp_valid, rsp_rdata, rsp_err); end
   endtask

   task automatic test_rr_subset();
      set_req(1, 1'b0, 8'h41, 8'h00);
      set_req(3, 1'b0, 8'h43, 8'h00);
      step();
      checks++; if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL sub_grant3: got %b required 1000", req_ready); end
      req_valid[3] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h80) begin
         errors++; $display("FAIL sub_rsp3: got %b %h required 1000 80", rsp_valid, rsp_rdata); end
      step();
      checks++; if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL sub_grant1: got %b required 0010", req_ready); end
      req_valid[1] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h82) begin
         errors++; $display("FAIL sub_rsp1: got %b %h required 0010 82", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_timeout();
      int seen;
      ctrl_on = 1'b0;
      set_req(1, 1'b0, 8'h20, 8'h00);
      step();
      checks++; if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL to_grant: got %b required 0010", req_ready); end
      req_valid[1] = 1'b0;
      seen = 0;
      for (int c = 2; c <= 16; c++) begin
         step();
         if (rsp_valid !== 4'b0000) seen++;
      end
      checks++; if (seen !== 0 || busy !== 1'b1) begin
         errors++; $display("FAIL to_early: got %0d rsp cycles busy %b required 0 busy 1", seen, busy); end
      step();
      checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL to_rsp: got %b err %b %h busy %b required 0010 1 00 0", rsp_valid, rsp_err, rsp_rdata, busy); end
      ctrl_on = 1'b1;
      set_req(0, 1'b1, 8'h20, 8'h3C);
      step();
      checks++; if (req_ready !== 4'b0001 || mc_wr_en !== 1'b1) begin
         errors++; $display("FAIL to_next_grant: got %b wr %b required 0001 1", req_ready, mc_wr_en); end
      req_valid[0] = 1'b0;
      repeat (3) step();
      checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL to_next_rsp: got %b err %b required 0001 0", rsp_valid, rsp_err); end
   endtask

   task automatic test_spurious();
      inj_ready = 1'b1;
      inj_data  = 8'h77;
      step();
      step();
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_rdata !== 8'h00) begin
         errors++; $display("FAIL sp_idle: got %b busy %b %h required 0000 0 00", rsp_valid, busy, rsp_rdata); end
      set_req(3, 1'b0, 8'h43, 8'h00);
      inj_ready = 1'b1;
      inj_data  = 8'h11;
      step();
      checks++; if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL sp_grant: got %b required 1000", req_ready); end
      req_valid[3] = 1'b0;
      step();
      checks++; if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL sp_issue: got %b required 0000", rsp_valid); end
      step();
      step();
      checks++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h80 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL sp_rsp: got %b %h err %b required 1000 80 0", rsp_valid, rsp_rdata, rsp_err); end
   endtask

   task automatic test_tie();
      ctrl_on = 1'b0;
      set_req(2, 1'b0, 8'h10, 8'h00);
      step();
      checks++; if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL tie_grant: got %b required 0100", req_ready); end
      req_valid[2] = 1'b0;
      repeat (14) step();
      inj_ready = 1'b1;
      inj_data  = 8'h5A;
      step();
      checks++; if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL tie_early: got %b required 0000", rsp_valid); end
      step();
      checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_rdata !== 8'h5A) begin
         errors++; $display("FAIL tie_rsp: got %b err %b %h required 0100 0 5a", rsp_valid, rsp_err, rsp_rdata); end
      ctrl_on = 1'b1;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      mc_rd_data = '0;
      mc_ready   = 1'b0;
      cnt        = 0;
      pend_addr  = '0;
      ctrl_on    = 1'b1;
      inj_ready  = 1'b0;
      inj_data   = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
      test_reset();
      test_round_robin();
      test_single_write();
      test_readback();
      test_rr_subset();
      test_timeout();
      test_spurious();
      test_tie();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
